credits_title_scroller: RTL and testbench

CREDITS_TITLE_SCROLLER -- requirements
Module: credits_title_scroller

---
 rtl/credits_title_scroller.sv | 199 +++++++++++++++++++
 tb/tb_credits_title_scroller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/credits_title_scroller.sv
// ----------------------------------------------------------------------------
// credits_title_scroller
//
// Scrolls a fixed-width title bitmap vertically from START_Y up to STOP_Y,
// SPEED rows per frame, holds it there for HOLD_FRAMES frames and then
// reports done. For every scan pixel it flags, one cycle later, whether the
// pixel falls inside the visible title rectangle and gives the pixel's offset
// from the title's top-left corner so a downstream bitmap ROM can be indexed.
//
// Optional feature macro: CREDITS_TITLE_BLINK_EN
//   When defined, the title blinks during HOLD (hidden whenever bit 4 of the
//   hold frame counter is set, i.e. 16 frames on / 16 frames off).
//
// Ports
//   clk             in   system clock
//   resetN          in   asynchronous active-low reset
//   startOfFrame    in   one-cycle pulse at the start of each frame
//   start           in   request to begin scrolling (honoured in IDLE/DONE)
//   pixelX[10:0]    in   current scan column
//   pixelY[10:0]    in   current scan row
//   offsetX[10:0]   out  column offset from title top-left (0 when outside)
//   offsetY[10:0]   out  row offset from title top-left (0 when outside)
//   InsideRectangle out  pixel lies inside the visible title rectangle
//   topLeftY[10:0]  out  current title top row
//   done            out  high while the scroll sequence is finished
// ----------------------------------------------------------------------------
module credits_title_scroller #(
    parameter int OBJECT_WIDTH  = 64,
    parameter int OBJECT_HEIGHT = 16,
    parameter int TOP_LEFT_X    = 288,
    parameter int START_Y       = 480,
    parameter int STOP_Y        = 100,
    parameter int SPEED         = 2,
    parameter int HOLD_FRAMES   = 120
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        start,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic [10:0] topLeftY,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCROLL,
        S_HOLD,
        S_DONE
    } state_t;

    // Horizontal bounds are 12 bits so the right edge never wraps.
    localparam logic [11:0] LP_X_LO      = 12'(TOP_LEFT_X);
    localparam logic [11:0] LP_X_HI      = 12'(TOP_LEFT_X + OBJECT_WIDTH);
    localparam logic [10:0] LP_X_LO11    = 11'(TOP_LEFT_X);
    localparam logic [11:0] LP_HEIGHT    = 12'(OBJECT_HEIGHT);
    localparam logic [10:0] LP_START_Y   = 11'(START_Y);
    localparam logic [10:0] LP_STOP_Y    = 11'(STOP_Y);
    localparam logic [10:0] LP_SPEED     = 11'(SPEED);
    // A full SPEED step is allowed only while it stays at or above STOP_Y;
    // comparing against STOP_Y+SPEED avoids an unsigned underflow.
    localparam logic [11:0] LP_STEP_MIN  = 12'(STOP_Y + SPEED);
    localparam logic [7:0]  LP_HOLD_LAST = 8'(HOLD_FRAMES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [10:0] r_top_y;
    logic [10:0] w_top_y_nxt;
    logic [7:0]  r_frame_cnt;
    logic [7:0]  w_frame_cnt_nxt;
    logic [10:0] w_top_y_step;

    logic [10:0] r_offset_x;
    logic [10:0] r_offset_y;
    logic        r_inside;
    logic [11:0] w_y_hi;
    logic        w_in_x;
    logic        w_in_y;
    logic        w_visible;
    logic        w_inside;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= S_IDLE;
            r_top_y     <= LP_START_Y;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_top_y     <= w_top_y_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_top_y_nxt     = r_top_y;
        w_frame_cnt_nxt = r_frame_cnt;

        if ({1'b0, r_top_y} >= LP_STEP_MIN) begin
            w_top_y_step = r_top_y - LP_SPEED;
        end else begin
            w_top_y_step = LP_STOP_Y;
        end

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SCROLL;
                    w_top_y_nxt = LP_START_Y;
                end
            end

            S_SCROLL: begin
                if (startOfFrame) begin
                    w_top_y_nxt = w_top_y_step;
                    if (w_top_y_step == LP_STOP_Y) begin
                        w_state_nxt     = S_HOLD;
                        w_frame_cnt_nxt = '0;
                    end
                end
            end

            S_HOLD: begin
                if (startOfFrame) begin
                    w_frame_cnt_nxt = r_frame_cnt + 8'd1;
                    if (r_frame_cnt == LP_HOLD_LAST) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end

            S_DONE: begin
                w_top_y_nxt = LP_STOP_Y;
                if (start) begin
                    w_state_nxt = S_SCROLL;
                    w_top_y_nxt = LP_START_Y;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_top_y_nxt = LP_START_Y;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pixel hit test. Uses the registered (pre-update) top row, so a
    // compare landing on a startOfFrame cycle sees the old position.
    // Rows past the bottom of the screen simply never match.
    // ------------------------------------------------------------------
    always_comb begin
        w_y_hi = {1'b0, r_top_y} + LP_HEIGHT;
        w_in_x = ({1'b0, pixelX} >= LP_X_LO) && ({1'b0, pixelX} < LP_X_HI);
        w_in_y = (pixelY >= r_top_y) && ({1'b0, pixelY} < w_y_hi);

        w_visible = (r_state != S_IDLE);
`ifdef CREDITS_TITLE_BLINK_EN
        if ((r_state == S_HOLD) && r_frame_cnt[4]) begin
            w_visible = 1'b0;
        end
`endif
        w_inside = w_visible && w_in_x && w_in_y;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_inside   <= 1'b0;
            r_offset_x <= '0;
            r_offset_y <= '0;
        end else begin
            r_inside <= w_inside;
            if (w_inside) begin
                r_offset_x <= pixelX - LP_X_LO11;
                r_offset_y <= pixelY - r_top_y;
            end else begin
                r_offset_x <= '0;
                r_offset_y <= '0;
            end
        end
    end

    assign offsetX         = r_offset_x;
    assign offsetY         = r_offset_y;
    assign InsideRectangle = r_inside;
    assign topLeftY        = r_top_y;
    assign done            = (r_state == S_DONE);

endmodule

// File: tb/tb_credits_title_scroller.sv
module tb_credits_title_scroller;

    localparam int TLX = 288;
    localparam int W   = 64;
    localparam int H   = 16;
    localparam int SY  = 480;
    localparam int EY  = 100;
    localparam int SP  = 2;
    localparam int HF  = 120;
`ifdef CREDITS_TITLE_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetN;
    logic        sof;
    logic        start;
    logic [10:0] px;
    logic [10:0] py;

    logic [10:0] offx, offy, topy;
    logic        ins, dn;
    logic [10:0] offx2, offy2, topy2;
    logic        ins2, dn2;

    always #5 clk = ~clk;

    credits_title_scroller dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .start(start),
        .pixelX(px), .pixelY(py), .offsetX(offx), .offsetY(offy),
        .InsideRectangle(ins), .topLeftY(topy), .done(dn)
    );

    // Second instance: SPEED=3. START_Y=481 makes the descent pass through
    // 103 (481-3*126) so the clamp to STOP_Y=100 (instead of 97) is visible.
    credits_title_scroller #(
        .START_Y(481), .SPEED(3), .HOLD_FRAMES(4)
    ) dut3 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .start(start),
        .pixelX(px), .pixelY(py), .offsetX(offx2), .offsetY(offy2),
        .InsideRectangle(ins2), .topLeftY(topy2), .done(dn2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: position as a function of frames elapsed.
    // phase 0=idle 1=scrolling 2=holding 3=finished
    // ------------------------------------------------------------------
    int m_phase, m_k, m_h;
    int e_y, e_ox, e_oy;
    bit e_in, e_dn;

    function automatic int y_after(input int k);
        int y;
        y = SY - SP * k;
        return (y < EY) ? EY : y;
    endfunction

    function automatic int cur_y();
        if (m_phase == 0) return SY;
        if (m_phase == 1) return y_after(m_k);
        return EY;
    endfunction

    always @(posedge clk or negedge resetN) begin : model
        int y;
        bit vis, hit;
        if (!resetN) begin
            m_phase = 0; m_k = 0; m_h = 0;
            e_in = 0; e_ox = 0; e_oy = 0; e_y = SY; e_dn = 0;
        end else begin
            y   = cur_y();
            vis = (m_phase != 0) && !(BLINK && m_phase == 2 && ((m_h / 16) % 2 == 1));
            hit = vis && int'(px) >= TLX && int'(px) < TLX + W
                      && int'(py) >= y && int'(py) < y + H;
            e_in = hit;
            e_ox = hit ? int'(px) - TLX : 0;
            e_oy = hit ? int'(py) - y : 0;
            if ((m_phase == 0 || m_phase == 3) && start) begin
                m_phase = 1; m_k = 0;
            end else if (m_phase == 1 && sof) begin
                m_k++;
                if (y_after(m_k) == EY) begin m_phase = 2; m_h = 0; end
            end else if (m_phase == 2 && sof) begin
                m_h++;
                if (m_h == HF) m_phase = 3;
            end
            e_y  = cur_y();
            e_dn = (m_phase == 3);
        end
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("topLeftY", topy, e_y);
            check("done", dn, e_dn);
            check("InsideRectangle", ins, e_in);
            check("offsetX", offx, e_ox);
            check("offsetY", offy, e_oy);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int xs[6]  = '{287, 288, 300, 351, 352, 320};
    int dys[6] = '{-1, 0, 5, 15, 16, 7};
    int pi     = 0;

    task automatic next_pix();
        px = 11'(xs[pi % 6]);
        py = 11'(e_y + dys[(pi / 7) % 6]);
        pi++;
    endtask

    // Five cycles per frame, startOfFrame on the last one.
    task automatic frame();
        repeat (4) begin @(negedge clk); next_pix(); end
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
        next_pix();
    endtask

    task automatic pix_check(input int x, input int y, input bit ein, input int eox, input int eoy);
        px = 11'(x); py = 11'(y);
        @(negedge clk);
        check("pix_inside", ins, 32'(ein));
        check("pix_offX", offx, eox);
        check("pix_offY", offy, eoy);
    endtask

    initial begin
        resetN = 1'b0; sof = 1'b0; start = 1'b0; px = '0; py = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_topLeftY", topy, 480);
        check("rst_done", dn, 0);
        check("rst_inside", ins, 0);
        check("rst_offX", offx, 0);
        check("rst_offY", offy, 0);
        @(negedge clk); #2 resetN = 1'b1;

        // Idle: a pixel that would hit the start position is not shown.
        @(negedge clk); px = 11'd300; py = 11'd485;
        @(negedge clk);
        check("idle_inside", ins, 0);

        // First run, aborted by reset at frame 50.
        start = 1'b1; @(negedge clk); start = 1'b0;
        check("start_y", topy, 480);
        frame();
        check("frame1_y", topy, 478);
        repeat (49) frame();
        check("frame50_y", topy, 380);
        #2 resetN = 1'b0;
        #1;
        check("abort_y", topy, 480);
        check("abort_done", dn, 0);
        check("abort_inside", ins, 0);
        check("abort_offX", offx, 0);
        check("abort_offY", offy, 0);
        repeat (2) @(negedge clk);
        #2 resetN = 1'b1;
        repeat (3) frame();
        check("idle_after_abort_y", topy, 480);
        check("idle_after_abort_done", dn, 0);

        // Second run to completion.
        @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
        for (int f = 1; f <= 190; f++) begin
            frame();
            if (f == 126) check("spd3_f126_y", topy2, 103);
            if (f == 127) check("spd3_f127_y", topy2, 100);
            if (f == 128) check("spd3_f128_y", topy2, 100);
            if (f == 189) check("frame189_y", topy, 102);
            if (f == 190) check("frame190_y", topy, 100);
            if (f == 190) check("frame190_done", dn, 0);
        end

        // Holding at row 100, hold counter 0.
        pix_check(288, 100, 1'b1, 0, 0);
        pix_check(351, 115, 1'b1, 63, 15);
        pix_check(352, 115, 1'b0, 0, 0);
        pix_check(288, 116, 1'b0, 0, 0);

        for (int h = 1; h <= HF; h++) begin
            frame();
            if (h == 20) begin
                px = 11'd300; py = 11'd105;
                @(negedge clk);
                check("hold_h20_inside", ins, BLINK ? 0 : 1);
            end
            if (h == 40) begin
                px = 11'd300; py = 11'd105;
                @(negedge clk);
                check("hold_h40_inside", ins, 1);
            end
            if (h == HF - 1) check("hold_h119_done", dn, 0);
            if (h == HF)     check("hold_h120_done", dn, 1);
        end

        // Restart from DONE.
        @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
        check("restart_y", topy, 480);
        check("restart_done", dn, 0);
        repeat (3) frame();
        check("restart_f3_y", topy, 474);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
